// File: rtl/game_pkg.sv
// Shared definitions between the 2048 game core and its command front end.
// State encoding and {start,btn} bit mapping live here so both sides agree.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_REL,
        GAP
    } state_e;

    localparam int CMD_UP    = 0;
    localparam int CMD_DOWN  = 1;
    localparam int CMD_LEFT  = 2;
    localparam int CMD_RIGHT = 3;
    localparam int CMD_START = 4;
    localparam int N_CMD     = 5;

    // Keep only the highest-index set bit: start beats btn[3] beats ... btn[0].
    function automatic logic [N_CMD-1:0] pick_cmd(
        input logic [N_CMD-1:0] p
    );
        logic [N_CMD-1:0] r;
        r = '0;
        for (int i = 0; i < N_CMD; i++) begin
            if (p[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_cmd_gen_if.sv
// Button/command bundle between the board buttons and the game core.
// master drives the raw buttons, slave is the command generator.
interface btn_cmd_gen_if;
    logic [3:0] btn_raw;
    logic       start_raw;
    logic [3:0] btn;
    logic       start;
    logic       busy;

    modport master (
        output btn_raw, start_raw,
        input  btn, start, busy
    );

    modport slave (
        input  btn_raw, start_raw,
        output btn, start, busy
    );
endinterface

// File: rtl/btn_cmd_gen_debounce.sv
// One raw button: 2-FF sync, hold-time debounce, registered rise pulse.
// The rise pulse lags the debounced level by one cycle.
module btn_debounce #(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DB_CYC + 1);

    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          db_dly_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_d;

    // Count consecutive disagreeing cycles; flip the level on the last one.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CW'(DB_CYC - 1)) begin
            cnt_d = '0;
            db_d  = ~db_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser, debounce state and rise detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            db_dly_q <= db_q;
            rise_q   <= db_q & ~db_dly_q;
        end
    end

    assign level_o = db_q;
    assign rise_o  = rise_q;
endmodule

// File: rtl/btn_cmd_gen.sv
// Turns five bouncy buttons into clean one-hot fixed-width command pulses.
// One command per press; presses outside IDLE are dropped, not queued.
module btn_cmd_gen
    import game_pkg::*;
#(
    parameter int DB_CYC    = 1_000_000,
    parameter int PULSE_CYC = 4,
    parameter int HOLDOFF   = 16
) (
    input  logic         clk,
    input  logic         rst,
    btn_cmd_gen_if.slave bus
);
    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int GW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [N_CMD-1:0] raw;
    logic [N_CMD-1:0] lvl;
    logic [N_CMD-1:0] press;
    logic             any_down;

    state_e           state_q;
    logic [N_CMD-1:0] cmd_q;
    logic             busy_q;
    logic [PW-1:0]    pcnt_q;
    logic [GW-1:0]    gcnt_q;

    assign raw = {bus.start_raw, bus.btn_raw};

    for (genvar i = 0; i < N_CMD; i++) begin : g_db
        btn_debounce #(
            .DB_CYC (DB_CYC)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw[i]),
            .level_o (lvl[i]),
            .rise_o  (press[i])
        );
    end

    assign any_down = |lvl;

    // Command FSM; outputs come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
            pcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|press) begin
                        cmd_q   <= pick_cmd(press);
                        busy_q  <= 1'b1;
                        pcnt_q  <= '0;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    if (int'(pcnt_q) >= PULSE_CYC - 1) begin
                        cmd_q   <= '0;
                        state_q <= WAIT_REL;
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                WAIT_REL: begin
                    if (!any_down) begin
                        gcnt_q  <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (HOLDOFF == 0 ||
                        int'(gcnt_q) >= HOLDOFF - 1) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end
                default: begin
                    cmd_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.btn   = cmd_q[CMD_RIGHT:CMD_UP];
    assign bus.start = cmd_q[CMD_START];
    assign bus.busy  = busy_q;
endmodule
